// File: rtl/rv32i_types.sv
// Shared RV32I type package: machine word, branch funct3 codes and the
// branch-history-table counter encoding with its saturating step helpers.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [2:0] {
      beq  = 3'b000,
      bne  = 3'b001,
      blt  = 3'b100,
      bge  = 3'b101,
      bltu = 3'b110,
      bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_t;

   localparam bht_state_t BHT_RESET_STATE = WNT;

   function automatic bht_state_t sat_inc(input bht_state_t s);
      return (s == ST) ? ST : bht_state_t'(s + 2'd1);
   endfunction

   function automatic bht_state_t sat_dec(input bht_state_t s);
      return (s == SNT) ? SNT : bht_state_t'(s - 2'd1);
   endfunction

   // The two unused funct3 codes (010, 011) are not branches.
   function automatic logic is_branch_funct3(input logic [2:0] f3);
      case (f3)
         beq, bne, blt, bge, bltu, bgeu: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bht_sat_counter_update.sv
// Next-state logic of one 2-bit saturating branch counter.
module bht_sat_counter_update
   import rv32i_types::*;
(
   input  bht_state_t state,
   input  logic       br_en,
   output bht_state_t next_state
);

   always_comb begin
      next_state = br_en ? sat_inc(state) : sat_dec(state);
   end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: 1-cycle lookup, 2-stage (read/stage, write) update
// with forwarding from the staging register, plus saturating statistics.
module bht_predictor
   import rv32i_types::*;
#(
   parameter int IDX_BITS = 6,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_valid,
   input  rv32i_word        fetch_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   input  logic             resolve_valid,
   input  rv32i_word        resolve_pc,
   input  logic [2:0]       resolve_funct3,
   input  logic             resolve_br_en,
   input  logic             resolve_pred,
   output logic             mispredict,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int ENTRIES = 1 << IDX_BITS;

   bht_state_t          table_q [ENTRIES];
   logic                stage_valid;
   logic [IDX_BITS-1:0] stage_idx;
   bht_state_t          stage_state;

   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] resolve_idx;
   bht_state_t          lookup_state;
   bht_state_t          resolve_cur;
   bht_state_t          resolve_next;
   logic                accept;
   logic                unused_pc_bits;

   assign fetch_idx      = fetch_pc[IDX_BITS+1:2];
   assign resolve_idx    = resolve_pc[IDX_BITS+1:2];
   assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                             resolve_pc[31:IDX_BITS+2], resolve_pc[1:0]};

   assign accept     = resolve_valid && is_branch_funct3(resolve_funct3);
   assign mispredict = accept && (resolve_br_en != resolve_pred);

   // A pending staged write is newer than the table copy for its index.
   always_comb begin
      lookup_state = table_q[fetch_idx];
      resolve_cur  = table_q[resolve_idx];
      if (stage_valid && stage_idx == fetch_idx)   lookup_state = stage_state;
      if (stage_valid && stage_idx == resolve_idx) resolve_cur  = stage_state;
   end

   bht_sat_counter_update u_update (
      .state      (resolve_cur),
      .br_en      (resolve_br_en),
      .next_state (resolve_next)
   );

   // NOTE: the table is reset per entry because every counter must start at WNT;
   // this keeps it in flops rather than an SRAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) table_q[i] <= BHT_RESET_STATE;
      end else if (stage_valid) begin
         table_q[stage_idx] <= stage_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid <= 1'b0;
         stage_idx   <= '0;
         stage_state <= BHT_RESET_STATE;
         pred_valid  <= 1'b0;
         pred_taken  <= 1'b0;
      end else begin
         stage_valid <= accept;
         if (accept) begin
            stage_idx   <= resolve_idx;
            stage_state <= resolve_next;
         end
         pred_valid <= fetch_valid;
         if (fetch_valid) pred_taken <= lookup_state[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (accept && branch_count != '1)
            branch_count <= branch_count + CNT_W'(1);
         if (mispredict && mispredict_count != '1)
            mispredict_count <= mispredict_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: predictions are checked through a
// scoreboard queue, mispredict and statistics against a small count model.
module tb_bht_predictor;
   import rv32i_types::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_valid;
   rv32i_word     fetch_pc;
   logic          pred_valid;
   logic          pred_taken;
   logic          resolve_valid;
   rv32i_word     resolve_pc;
   logic [2:0]    resolve_funct3;
   logic          resolve_br_en;
   logic          resolve_pred;
   logic          mispredict;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;

   int            checks = 0;
   int            errors = 0;
   bit            sb [$];
   logic [CW-1:0] exp_br = '0;
   logic [CW-1:0] exp_mis = '0;

   bht_predictor #(.IDX_BITS(6), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_valid      (fetch_valid),
      .fetch_pc         (fetch_pc),
      .pred_valid       (pred_valid),
      .pred_taken       (pred_taken),
      .resolve_valid    (resolve_valid),
      .resolve_pc       (resolve_pc),
      .resolve_funct3   (resolve_funct3),
      .resolve_br_en    (resolve_br_en),
      .resolve_pred     (resolve_pred),
      .mispredict       (mispredict),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each prediction is compared with the oldest expectation pushed at fetch time.
   always @(negedge clk) begin
      if (rst_n && pred_valid) begin
         if (sb.size() == 0) begin
            check("pred_unexpected", 32'd1, 32'd0);
         end else begin
            check("pred_taken", {31'd0, pred_taken}, {31'd0, sb.pop_front()});
         end
      end
   end

   function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   task automatic drive(input bit fv, input rv32i_word fpc, input bit exp_pred,
                        input bit rv, input rv32i_word rpc, input logic [2:0] f3,
                        input bit br, input bit pr, input bit exp_mp);
      fetch_valid    = fv;
      fetch_pc       = fpc;
      resolve_valid  = rv;
      resolve_pc     = rpc;
      resolve_funct3 = f3;
      resolve_br_en  = br;
      resolve_pred   = pr;
      if (fv) sb.push_back(exp_pred);
      #1;
      check("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
      if (rv && (f3 inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111})) begin
         exp_br = sat_add(exp_br);
         if (br != pr) exp_mis = sat_add(exp_mis);
      end
      @(posedge clk);
      #1;
      fetch_valid   = 1'b0;
      resolve_valid = 1'b0;
      check("branch_count", 32'(branch_count), 32'(exp_br));
      check("mispredict_count", 32'(mispredict_count), 32'(exp_mis));
   endtask

   task automatic fetch(input rv32i_word pc, input bit exp_pred);
      drive(1'b1, pc, exp_pred, 1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic resolve(input rv32i_word pc, input logic [2:0] f3, input bit br,
                          input bit pr, input bit exp_mp);
      drive(1'b0, '0, 1'b0, 1'b1, pc, f3, br, pr, exp_mp);
   endtask

   task automatic both(input rv32i_word fpc, input bit exp_pred, input rv32i_word rpc,
                       input bit br, input bit pr, input bit exp_mp);
      drive(1'b1, fpc, exp_pred, 1'b1, rpc, 3'b000, br, pr, exp_mp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      fetch_valid = 1'b0; fetch_pc = '0;
      resolve_valid = 1'b0; resolve_pc = '0; resolve_funct3 = '0;
      resolve_br_en = 1'b0; resolve_pred = 1'b0;
      #3;
      check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rst_mispredict", {31'd0, mispredict}, 32'd0);
      check("rst_branch_count", 32'(branch_count), 32'd0);
      check("rst_mispredict_count", 32'(mispredict_count), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state is WNT, then a mispredicted taken update makes it WT.
      fetch(32'h0000_0040, 1'b0);
      resolve(32'h0000_0040, 3'b000, 1'b1, 1'b0, 1'b1);
      fetch(32'h0000_0040, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0);
      check("idle_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("idle_pred_hold", {31'd0, pred_taken}, 32'd1);

      // Back-to-back updates on 0x80 with a same-cycle lookup each time.
      both(32'h0000_0080, 1'b0, 32'h0000_0080, 1'b1, 1'b1, 1'b0); // WNT->WT
      both(32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b0); // WT->ST
      both(32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b0); // ST->ST
      both(32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b1); // ST->WT
      fetch(32'h0000_0080, 1'b1);
      resolve(32'h0000_0080, 3'b100, 1'b0, 1'b1, 1'b1);            // WT->WNT
      fetch(32'h0000_0080, 1'b0);

      // Invalid funct3 must leave the entry, counters and mispredict alone.
      resolve(32'h0000_0080, 3'b010, 1'b1, 1'b0, 1'b0);
      resolve(32'h0000_0080, 3'b011, 1'b1, 1'b0, 1'b0);
      fetch(32'h0000_0080, 1'b0);

      // Aliasing: 0x4 and 0x104 share index 1; 0x8 is a different entry.
      resolve(32'h0000_0004, 3'b111, 1'b1, 1'b0, 1'b1);
      fetch(32'h0000_0104, 1'b1);
      fetch(32'h0000_0008, 1'b0);

      // Drive both statistics counters into saturation.
      for (int i = 0; i < 12; i++) begin
         resolve(32'h0000_000C, 3'b001, i[0], ~i[0], 1'b1);
      end
      check("branch_count_sat", 32'(branch_count), 32'hF);
      check("mispredict_count_sat", 32'(mispredict_count), 32'hF);

      // Reset right after an accept drops the staged write.
      resolve(32'h0000_0010, 3'b000, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      exp_br = '0;
      exp_mis = '0;
      #1;
      check("midrst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("midrst_branch_count", 32'(branch_count), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      fetch(32'h0000_0010, 1'b0);
      fetch(32'h0000_0040, 1'b0);
      fetch(32'h0000_0104, 1'b0);

      @(negedge clk); #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Branch-history-table predictor at the front end of the branch path. It predicts br_en for a fetched branch before the branch comparator resolves it in execute.
- It later consumes the resolved br_en and updates its 2-bit saturating counters.
- It flags mispredictions to the datapath's PC-redirect logic and keeps branch and mispredict statistics.

Parameters:
- IDX_BITS, 6, log2 of table entries (64 entries); index = pc[IDX_BITS+1:2]
- CNT_W, 32, width of the statistics counters

Ports:
- clk, input, 1, system clock; all state updates on rising edge
- rst_n, input, 1, asynchronous active-low reset
- fetch_valid, input, 1, lookup request this cycle
- fetch_pc, input, 32, PC of fetched instruction (rv32i_word)
- pred_valid, output, 1, prediction available (fetch_valid delayed one cycle)
- pred_taken, output, 1, predicted br_en for the previous cycle's fetch_pc
- resolve_valid, input, 1, a branch resolved in execute this cycle
- resolve_pc, input, 32, PC of resolving branch
- resolve_funct3, input, 3, branch_funct3_t of resolving branch
- resolve_br_en, input, 1, actual outcome from the comparator
- resolve_pred, input, 1, prediction carried down the pipe with that branch
- mispredict, output, 1, resolve_valid and resolve_br_en != resolve_pred, for an accepted update (combinational)
- branch_count, output, CNT_W, accepted resolves since reset
- mispredict_count, output, CNT_W, mispredicts since reset

Behaviour:
- Reset: asynchronous, active-low.
  - All entries go to WNT (01).
  - pred_valid=0, pred_taken=0.
  - Staging register is invalidated, so a pending update is discarded.
  - Both counters are cleared to 0.
  - mispredict=0 as long as resolve_valid=0.
  - Reset asserted mid-operation discards all in-flight state; nothing is written afterwards.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11. Prediction = counter MSB.
- Lookup, 1-cycle latency:
  - A fetch in cycle N yields pred_valid=1 and pred_taken in cycle N+1.
  - With fetch_valid=0, pred_valid=0 next cycle and pred_taken holds its last value.
- Update acceptance: resolve_funct3 must be one of beq, bne, blt, bge, bltu, bgeu.
  - Any other value is ignored entirely: no write, no count, mispredict=0.
- Update pipeline, 2 stages:
  - Cycle N (accept): read the current counter for idx(resolve_pc). Compute next = sat_inc if br_en=1, else sat_dec. Latch {valid, idx, next} into the staging register.
  - Cycle N+1: write the staged value into the table.
- Saturation: ST stays ST on taken; SNT stays SNT on not-taken. No wrap.
- Forwarding:
  - A lookup or accept whose index matches a valid staging entry uses the staged value, not the table value.
  - Back-to-back updates to the same index therefore compound, e.g. WNT,taken,taken -> ST.
- Simultaneous lookup and accept to the same index in cycle N: the lookup sees the pre-update value (the staged value only if one is already pending from N-1).
- Statistics:
  - branch_count increments by 1 per accepted resolve.
  - mispredict_count increments by 1 per mispredict.
  - Both saturate at all-ones; they do not wrap.
- Aliasing: PCs with equal idx share an entry. There are no tags.

Decomposition:
- rv32i_types (shared package): add bht_state_t enum {SNT, WNT, WT, ST}, a sat_inc/sat_dec function pair, and BHT_RESET_STATE = WNT. branch_funct3_t is reused from the same package.
- One sub-module: bht_sat_counter_update. It is a pure function of (state, br_en) producing next state, instantiated or called in the accept stage.

Test Plan:
- Reset, then fetch 0x00000040 -> next cycle pred_valid=1, pred_taken=0 (WNT); branch_count=0.
- Resolve pc=0x40, beq, br_en=1, pred=0 -> mispredict=1 same cycle. After writeback, fetch 0x40 -> pred_taken=1 (WT); mispredict_count=1.
- Three back-to-back taken resolves on 0x80, then one not-taken -> entry ST after the third, WT after the fourth. Fetch 0x80 -> pred_taken=1, confirming forwarding on every cycle.
- Resolve with resolve_funct3=3'b010 (invalid) -> no table change, branch_count unchanged, mispredict=0.
- Alias check with IDX_BITS=6: taken update on 0x00000004 -> fetch 0x00000104 predicts taken. Fetch 0x00000008 still predicts not-taken.
- Force branch_count to all-ones and resolve once more -> it stays all-ones. Assert rst_n=0 one cycle after an accept -> staged write lost, entry reads WNT after reset.
